// File: rtl/addsub_serial_if.sv
// addsub_serial handshake bundle
// operand request side and result/flag side
interface addsub_serial_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid,
    output op,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  carry,
    input  overflow,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  op,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output carry,
    output overflow,
    output zero
  );

endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: bit-serial add/sub/inc/dec stage
// one result bit per clock, LSB first
module addsub_serial #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  addsub_serial_if.slave io
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             rc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] sr;

  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  logic             acc;
  logic             last;
  logic             s;
  logic             co;
  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-1:0] bsel;
  logic             csel;

  // bit-slice full adder and handshake qualifiers
  always_comb begin
    acc    = (state == IDLE) && io.in_valid;
    last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    s      = ra[0] ^ rb[0] ^ rc;
    co     = (ra[0] & rb[0]) | (ra[0] & rc) | (rb[0] & rc);
    sum_nx = {s, sr};
  end

  // opcode to B operand and initial carry
  always_comb begin
    bsel = '0;
    csel = 1'b0;
    unique case (io.op)
      2'b00: begin
        bsel = io.b;
      end
      2'b01: begin
        bsel = ~io.b;
        csel = 1'b1;
      end
      2'b10: begin
        csel = 1'b1;
      end
      2'b11: begin
        bsel = '1;
      end
      default: begin
        bsel = '0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (io.in_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // operand shift, carry chain and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra      <= '0;
      rb      <= '0;
      rc      <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (acc) begin
      ra  <= io.a;
      rb  <= bsel;
      rc  <= csel;
      cnt <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rc  <= co;
      cnt <= cnt + CW'(1);
      sr  <= sum_nx[WIDTH-1:1];
      if (last) begin
        res_q   <= sum_nx;
        carry_q <= co;
        ovf_q   <= rc ^ co;
        zero_q  <= (sum_nx == '0);
      end
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.result    = res_q;
  assign io.carry     = carry_q;
  assign io.overflow  = ovf_q;
  assign io.zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: model-checked bench
// for the bit-serial add/sub unit
module tb_addsub_serial;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(W)) bus ();

  addsub_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_acc = 0;
  int   b2b_n = 0;
  bit   b2b = 1'b0;
  bit   pending = 1'b0;
  bit   prev_ov = 1'b0;
  exp_t expq = '0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, req);
    end
  endfunction

  function automatic exp_t model(logic [1:0] op,
                                 logic [W-1:0] a,
                                 logic [W-1:0] b);
    int   m;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   full;
    int   sr;
    exp_t e;
    m  = 1 << W;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - m : ua;
    sb = b[W-1] ? ub - m : ub;
    full = 0;
    sr = 0;
    e = '0;
    case (op)
      2'b00: begin
        full = ua + ub;
        e.c  = (full >= m);
        sr   = sa + sb;
      end
      2'b01: begin
        full = ua + m - ub;
        e.c  = (ua >= ub);
        sr   = sa - sb;
      end
      2'b10: begin
        full = ua + 1;
        e.c  = (ua == m - 1);
        sr   = sa + 1;
      end
      default: begin
        full = ua + m - 1;
        e.c  = (ua != 0);
        sr   = sa - 1;
      end
    endcase
    e.res = W'(full % m);
    e.v   = (sr > m / 2 - 1) || (sr < -(m / 2));
    e.z   = ((full % m) == 0);
    return e;
  endfunction

  // accept tracking and reference capture
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      cyc++;
      if (bus.out_valid && bus.out_ready) begin
        pending = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (b2b) begin
          if (b2b_n > 0) begin
            chk("accept_interval",
                32'(cyc - acc_cyc), 32'(W + 2));
          end
          b2b_n++;
        end
        expq    = model(bus.op, bus.a, bus.b);
        pending = 1'b1;
        acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  // output check on every valid cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (!pending) begin
          chk("spurious_valid", 32'(1), 32'(0));
        end else begin
          if (!prev_ov) begin
            chk("latency", 32'(cyc - acc_cyc), 32'(W));
          end
          chk("result", 32'(bus.result), 32'(expq.res));
          chk("carry", 32'(bus.carry), 32'(expq.c));
          chk("overflow", 32'(bus.overflow), 32'(expq.v));
          chk("zero", 32'(bus.zero), 32'(expq.z));
          chk("in_ready_busy", 32'(bus.in_ready), 32'(0));
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic wait_accept();
    int  start;
    bit  ok;
    start = n_acc;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (n_acc != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'(0), 32'(1));
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        break;
      end
    end
    chk("valid_timeout", 32'(bus.out_valid), 32'(1));
  endtask

  task automatic run_dir(string nm,
                         logic [1:0] op,
                         logic [W-1:0] a,
                         logic [W-1:0] b,
                         logic [W-1:0] res,
                         logic c,
                         logic v,
                         logic z);
    exp_t m;
    m = model(op, a, b);
    chk({nm, "_model"}, 32'(m), 32'({res, c, v, z}));
    @(negedge clk);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    wait_valid();
    chk({nm, "_res"}, 32'(bus.result), 32'(res));
    chk({nm, "_c"}, 32'(bus.carry), 32'(c));
    chk({nm, "_v"}, 32'(bus.overflow), 32'(v));
    chk({nm, "_z"}, 32'(bus.zero), 32'(z));
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'(1));
  endtask

  initial begin
    logic [W-1:0] snap_r;
    logic [2:0]   snap_f;
    int           n0;
    int           start;

    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_result", 32'(bus.result), 32'(0));
    chk("rst_flags",
        32'({bus.carry, bus.overflow, bus.zero}), 32'(0));
    rst_n = 1'b1;

    run_dir("add_7_5", 2'b00, 4'd7, 4'd5,
            4'hC, 1'b0, 1'b1, 1'b0);
    run_dir("sub_3_5", 2'b01, 4'd3, 4'd5,
            4'hE, 1'b0, 1'b0, 1'b0);
    run_dir("sub_5_3", 2'b01, 4'd5, 4'd3,
            4'h2, 1'b1, 1'b0, 1'b0);
    run_dir("dec_0", 2'b11, 4'd0, W'($urandom),
            4'hF, 1'b0, 1'b0, 1'b0);
    run_dir("dec_1", 2'b11, 4'd1, W'($urandom),
            4'h0, 1'b1, 1'b0, 1'b1);
    run_dir("dec_8", 2'b11, 4'd8, W'($urandom),
            4'h7, 1'b1, 1'b1, 1'b0);
    run_dir("inc_f", 2'b10, 4'hF, W'($urandom),
            4'h0, 1'b1, 1'b0, 1'b1);
    run_dir("inc_7", 2'b10, 4'h7, W'($urandom),
            4'h8, 1'b0, 1'b1, 1'b0);

    // backpressure
    @(negedge clk);
    bus.op        = 2'b00;
    bus.a         = 4'd9;
    bus.b         = 4'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    wait_accept();
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid();
    snap_r = bus.result;
    snap_f = {bus.carry, bus.overflow, bus.zero};
    chk("bp_res", 32'(snap_r), 32'(4'hC));
    n0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = 2'($urandom);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
      chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_hold_res", 32'(bus.result), 32'(snap_r));
      chk("bp_hold_flags",
          32'({bus.carry, bus.overflow, bus.zero}),
          32'(snap_f));
    end
    chk("bp_no_accept", 32'(n_acc), 32'(n0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
    chk("bp_release_valid", 32'(bus.out_valid), 32'(0));

    // reset mid-run
    @(negedge clk);
    bus.op       = 2'b00;
    bus.a        = 4'd6;
    bus.b        = 4'd7;
    bus.in_valid = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(bus.out_valid), 32'(0));
    chk("mr_in_ready", 32'(bus.in_ready), 32'(1));
    chk("mr_result", 32'(bus.result), 32'(0));
    chk("mr_flags",
        32'({bus.carry, bus.overflow, bus.zero}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mr_quiet", 32'(bus.out_valid), 32'(0));
    end

    // back-to-back random
    @(negedge clk);
    b2b_n         = 0;
    b2b           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    start         = n_acc;
    for (int i = 0; i < 16 * (W + 2) + 20; i++) begin
      bus.op = 2'($urandom);
      bus.a  = W'($urandom);
      bus.b  = W'($urandom);
      @(negedge clk);
      if (n_acc - start >= 16) begin
        break;
      end
    end
    bus.in_valid = 1'b0;
    repeat (W + 4) @(negedge clk);
    b2b = 1'b0;
    chk("b2b_count", 32'(n_acc - start), 32'(16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
